// File: rtl/color_mapping_jet_rgb_pipe_if.sv
// AXI4-Stream style beat bundle (data, valid/ready, start-of-frame user bit, end-of-line last bit).
interface color_mapping_jet_rgb_pipe_if #(
    parameter int DATA_W = 50
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/color_mapping_jet_rgb_pipe.sv
// Two-stage pipeline turning a signed multiplier product into a jet-colormap RGB pixel,
// with per-frame counts of beats clamped to the low and high ends of the index range.
module color_mapping_jet_rgb_pipe #(
    parameter int SHIFT      = 34,
    parameter int PROD_WIDTH = 50
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    color_mapping_jet_rgb_pipe_if.slave         s_axis,
    color_mapping_jet_rgb_pipe_if.master        m_axis,
    output logic [15:0]                         sat_lo_cnt,
    output logic [15:0]                         sat_hi_cnt
);

    // Result packing: bit 9 = clamped low, bit 8 = clamped high, bits 7:0 = index.
    function automatic logic [9:0] clamp_idx(input logic signed [PROD_WIDTH-1:0] prod);
        logic signed [PROD_WIDTH-1:0] sh;
        logic                         neg;
        logic                         over;
        sh   = prod >>> SHIFT;
        neg  = sh[PROD_WIDTH-1];
        over = ~neg & (|sh[PROD_WIDTH-2:8]);
        if (neg)
            clamp_idx = {2'b10, 8'h00};
        else if (over)
            clamp_idx = {2'b01, 8'hFF};
        else
            clamp_idx = {2'b00, sh[7:0]};
    endfunction

    function automatic logic [23:0] jet(input logic [7:0] idx);
        logic [7:0] f4;
        f4 = {idx[5:0], 2'b00};
        case (idx[7:6])
            2'd0:    jet = {8'h00, f4, 8'hFF};
            2'd1:    jet = {8'h00, 8'hFF, 8'hFF - f4};
            2'd2:    jet = {f4, 8'hFF, 8'h00};
            default: jet = {8'hFF, 8'hFF - f4, 8'h00};
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic        en;
    logic        acc;
    logic [9:0]  clamp_in;

    logic        vld_p1;
    logic        user_p1;
    logic        last_p1;
    logic [7:0]  idx_p1;

    logic        vld_p2;
    logic        user_p2;
    logic        last_p2;
    logic [23:0] pix_p2;

    assign en            = m_axis.tready | ~vld_p2;
    assign acc           = s_axis.tvalid & en;
    assign s_axis.tready = en;
    assign clamp_in      = clamp_idx(s_axis.tdata);

    // Stage 1: shift and clamp to an 8-bit colour index
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_p1  <= 1'b0;
            user_p1 <= 1'b0;
            last_p1 <= 1'b0;
            idx_p1  <= 8'h00;
        end else if (en) begin
            vld_p1  <= acc;
            user_p1 <= s_axis.tuser;
            last_p1 <= s_axis.tlast;
            idx_p1  <= clamp_in[7:0];
        end
    end

    // Stage 2: colormap lookup into the output register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_p2  <= 1'b0;
            user_p2 <= 1'b0;
            last_p2 <= 1'b0;
            pix_p2  <= 24'h000000;
        end else if (en) begin
            vld_p2  <= vld_p1;
            user_p2 <= user_p1;
            last_p2 <= last_p1;
            pix_p2  <= jet(idx_p1);
        end
    end

    // A start-of-frame beat restarts both counts from its own clamp flags.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_lo_cnt <= 16'h0000;
            sat_hi_cnt <= 16'h0000;
        end else if (acc) begin
            if (s_axis.tuser) begin
                sat_lo_cnt <= {15'd0, clamp_in[9]};
                sat_hi_cnt <= {15'd0, clamp_in[8]};
            end else begin
                if (clamp_in[9])
                    sat_lo_cnt <= sat_inc(sat_lo_cnt);
                if (clamp_in[8])
                    sat_hi_cnt <= sat_inc(sat_hi_cnt);
            end
        end
    end

    assign m_axis.tvalid = vld_p2;
    assign m_axis.tuser  = user_p2;
    assign m_axis.tlast  = last_p2;
    assign m_axis.tdata  = pix_p2;

endmodule

// File: tb/tb_color_mapping_jet_rgb_pipe.sv
// Randomised bench for the jet colormap pipeline: a queue-based reference model of the
// product-to-pixel mapping and per-frame clamp counters, plus directed boundary scenarios.
module tb_color_mapping_jet_rgb_pipe;
    localparam int PW    = 50;
    localparam int SHIFT = 34;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [15:0] sat_lo_cnt;
    logic [15:0] sat_hi_cnt;

    color_mapping_jet_rgb_pipe_if #(.DATA_W(PW)) s_if ();
    color_mapping_jet_rgb_pipe_if #(.DATA_W(24)) m_if ();

    color_mapping_jet_rgb_pipe #(.SHIFT(SHIFT), .PROD_WIDTH(PW)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .sat_lo_cnt (sat_lo_cnt),
        .sat_hi_cnt (sat_hi_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [23:0] pix;
        logic        user;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          lo_m = 0;
    int          hi_m = 0;
    bit          stalled = 0;
    logic [23:0] held_d;
    logic        held_u;
    logic        held_l;

    // Reference: floor-divide by 2^SHIFT, clamp to 0..255, then piecewise-linear jet ramps.
    function automatic void ref_model(input longint p, output logic [23:0] pix,
                                      output bit lo, output bit hi);
        longint k;
        int     idx, f, r, g, b;
        k   = p >>> SHIFT;
        lo  = (k < 0);
        hi  = (k > 255);
        idx = lo ? 0 : (hi ? 255 : int'(k));
        f   = (idx % 64) * 4;
        case (idx / 64)
            0:       begin r = 0;   g = f;       b = 255;     end
            1:       begin r = 0;   g = 255;     b = 255 - f; end
            2:       begin r = f;   g = 255;     b = 0;       end
            default: begin r = 255; g = 255 - f; b = 0;       end
        endcase
        pix = {8'(r), 8'(g), 8'(b)};
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            exp_q.delete();
            lo_m    = 0;
            hi_m    = 0;
            stalled = 0;
        end else begin
            checks++;
            if (sat_lo_cnt !== 16'(lo_m) || sat_hi_cnt !== 16'(hi_m)) begin
                failures++;
                $display("FAIL counters: got lo=%0d hi=%0d expected lo=%0d hi=%0d",
                         sat_lo_cnt, sat_hi_cnt, lo_m, hi_m);
            end
            if (stalled) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== held_d ||
                    m_if.tuser !== held_u || m_if.tlast !== held_l) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%06h u=%b l=%b expected v=1 d=%06h u=%b l=%b",
                             m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast, held_d, held_u, held_l);
                end
            end
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got d=%06h with no beat outstanding", m_if.tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (m_if.tdata !== e.pix || m_if.tuser !== e.user || m_if.tlast !== e.last) begin
                        failures++;
                        $display("FAIL out_beat: got d=%06h u=%b l=%b expected d=%06h u=%b l=%b",
                                 m_if.tdata, m_if.tuser, m_if.tlast, e.pix, e.user, e.last);
                    end
                end
            end
            stalled = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
            held_d  = m_if.tdata;
            held_u  = m_if.tuser;
            held_l  = m_if.tlast;
            if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) begin
                beat_t n;
                bit    lo, hi;
                ref_model(longint'($signed(s_if.tdata)), n.pix, lo, hi);
                n.user = s_if.tuser;
                n.last = s_if.tlast;
                exp_q.push_back(n);
                if (s_if.tuser) begin
                    lo_m = int'(lo);
                    hi_m = int'(hi);
                end else begin
                    if (lo && lo_m < 65535) lo_m++;
                    if (hi && hi_m < 65535) hi_m++;
                end
            end
        end
    end

    // Presents one beat from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic send(input longint p, input logic u, input logic l);
        int guard;
        guard       = 0;
        s_if.tdata  = PW'(p);
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge ap_clk);
        while (s_if.tready !== 1'b1 && guard < 500) begin
            @(negedge ap_clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got tready=%b expected 1 within 500 cycles", s_if.tready);
        end
        @(posedge ap_clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard       = 0;
        m_if.tready = 1'b1;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
        end
        @(posedge ap_clk);
        #1;
    endtask

    function automatic longint rand_prod();
        longint k, low;
        k   = longint'($urandom_range(0, 400)) - 72;
        low = (longint'($urandom_range(0, 3)) <<< 32) + longint'($urandom);
        return (k <<< SHIFT) + low;
    endfunction

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        ap_rst_n    = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 24'h000000 || m_if.tuser !== 1'b0 ||
            m_if.tlast !== 1'b0 || sat_lo_cnt !== 16'h0 || sat_hi_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%06h u=%b l=%b lo=%0d hi=%0d expected all zero",
                     m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast, sat_lo_cnt, sat_hi_cnt);
        end
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", s_if.tready);
        end
    endtask

    task automatic test_flow();
        m_if.tready = 1'b1;
        send(64'sd100 <<< SHIFT, 1'b0, 1'b0);
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            failures++;
            $display("FAIL flow_early: got tvalid=%b expected 0 one cycle after acceptance", m_if.tvalid);
        end
        @(posedge ap_clk);
        #1;
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h00FF6F) begin
            failures++;
            $display("FAIL flow_latency: got v=%b d=%06h expected v=1 d=00ff6f", m_if.tvalid, m_if.tdata);
        end
        checks++;
        if (sat_lo_cnt !== 16'h0 || sat_hi_cnt !== 16'h0) begin
            failures++;
            $display("FAIL flow_counters: got lo=%0d hi=%0d expected 0 0", sat_lo_cnt, sat_hi_cnt);
        end
        drain();
    endtask

    task automatic test_clamp();
        longint      p[3]  = '{-64'sd5, 64'sd300 <<< SHIFT, 64'sd255 <<< SHIFT};
        logic [23:0] ed[3] = '{24'h0000FF, 24'hFF0300, 24'hFF0300};
        int          elo[3] = '{1, 1, 1};
        int          ehi[3] = '{0, 1, 1};
        m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(p[i], (i == 0), 1'b0);
            @(posedge ap_clk);
            #1;
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== ed[i] ||
                sat_lo_cnt !== 16'(elo[i]) || sat_hi_cnt !== 16'(ehi[i])) begin
                failures++;
                $display("FAIL clamp_%0d: got v=%b d=%06h lo=%0d hi=%0d expected v=1 d=%06h lo=%0d hi=%0d",
                         i, m_if.tvalid, m_if.tdata, sat_lo_cnt, sat_hi_cnt, ed[i], elo[i], ehi[i]);
            end
        end
        drain();
    endtask

    task automatic test_segments();
        int          idx[6] = '{63, 64, 127, 128, 191, 192};
        logic [23:0] ed[6]  = '{24'h00FCFF, 24'h00FFFF, 24'h00FF03, 24'h00FF00, 24'hFCFF00, 24'hFFFF00};
        m_if.tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send((longint'(idx[i]) <<< SHIFT) + longint'($urandom_range(0, 100000)), 1'b0, 1'b0);
            @(posedge ap_clk);
            #1;
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== ed[i]) begin
                failures++;
                $display("FAIL segment_idx%0d: got v=%b d=%06h expected v=1 d=%06h",
                         idx[i], m_if.tvalid, m_if.tdata, ed[i]);
            end
        end
        drain();
    endtask

    task automatic test_frame_reset();
        m_if.tready = 1'b1;
        send(64'sd400 <<< SHIFT, 1'b1, 1'b0);
        send(64'sd500 <<< SHIFT, 1'b0, 1'b0);
        send(64'sd300 <<< SHIFT, 1'b0, 1'b1);
        checks++;
        if (sat_hi_cnt !== 16'd3 || sat_lo_cnt !== 16'd0) begin
            failures++;
            $display("FAIL frame_hi3: got lo=%0d hi=%0d expected lo=0 hi=3", sat_lo_cnt, sat_hi_cnt);
        end
        send(-(64'sd1 <<< 40), 1'b1, 1'b0);
        checks++;
        if (sat_hi_cnt !== 16'd0 || sat_lo_cnt !== 16'd1) begin
            failures++;
            $display("FAIL frame_restart: got lo=%0d hi=%0d expected lo=1 hi=0", sat_lo_cnt, sat_hi_cnt);
        end
        drain();
    endtask

    task automatic test_backpressure(input int n, input bit gaps);
        bit done;
        done = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        @(posedge ap_clk);
                        #1;
                    end
                    send(rand_prod(), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    m_if.tready = 1'($urandom_range(0, 1));
                    @(posedge ap_clk);
                    #1;
                end
            end
        join
        drain();
    endtask

    task automatic test_reset_midstream();
        m_if.tready = 1'b0;
        send(64'sd10 <<< SHIFT, 1'b0, 1'b0);
        send(64'sd300 <<< SHIFT, 1'b0, 1'b1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 24'h000000 ||
            sat_lo_cnt !== 16'h0 || sat_hi_cnt !== 16'h0) begin
            failures++;
            $display("FAIL midreset_clear: got v=%b d=%06h lo=%0d hi=%0d expected all zero",
                     m_if.tvalid, m_if.tdata, sat_lo_cnt, sat_hi_cnt);
        end
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: got %b expected 1", s_if.tready);
        end
        m_if.tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge ap_clk);
            checks++;
            if (m_if.tvalid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_stale: got tvalid=%b d=%06h expected tvalid=0", m_if.tvalid, m_if.tdata);
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_flow();
        test_clamp();
        test_segments();
        test_frame_reset();
        test_backpressure(20, 1'b0);
        test_backpressure(150, 1'b1);
        test_reset_midstream();
        test_flow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/color_mapping_jet_rgb_pipe.md
COLOR_MAPPING_JET_RGB_PIPE -- requirements
Module: color_mapping_jet_rgb_pipe

Interface
REQ-001 SHALL have parameter SHIFT, default 34, arithmetic right-shift applied to the product to form the colour index.
REQ-002 SHALL have parameter PROD_WIDTH, default 50, width of the signed product input.
REQ-003 ap_clk  in  1  sole clock; all state rising-edge.
REQ-004 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_axis_tdata  in  PROD_WIDTH  signed product from the colour-mapping multiplier.
REQ-006 s_axis_tvalid  in  1  input beat valid.
REQ-007 s_axis_tready  out  1  input beat accepted when tvalid&tready.
REQ-008 s_axis_tuser  in  1  start-of-frame marker.
REQ-009 s_axis_tlast  in  1  end-of-line marker.
REQ-010 m_axis_tdata  out  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-011 m_axis_tvalid  out  1  output beat valid.
REQ-012 m_axis_tready  in  1  downstream ready.
REQ-013 m_axis_tuser  out  1  tuser delayed with its pixel.
REQ-014 m_axis_tlast  out  1  tlast delayed with its pixel.
REQ-015 sat_lo_cnt  out  16  beats in current frame clamped to index 0.
REQ-016 sat_hi_cnt  out  16  beats in current frame clamped to index 255.

Function
REQ-017 Pipeline enable en = m_axis_tready | ~m_axis_tvalid; s_axis_tready SHALL equal en (combinational).
REQ-018 Stage 1 (on en): register v1 = s_axis_tvalid&en, tuser, tlast, idx = clamp(s_axis_tdata >>> SHIFT, 0, 255).
REQ-019 Shift SHALL be arithmetic (sign-preserving); shifted value <0 -> idx 0 with lo flag; >255 -> idx 255 with hi flag; exactly 0 or 255 SHALL NOT set flags.
REQ-020 Stage 2 (on en): register m_axis_tvalid = v1, tuser, tlast, tdata = jet(idx).
REQ-021 jet: seg = idx[7:6], f4 = 4*idx[5:0] (0..252).
REQ-022 seg0: R=0, G=f4, B=255; seg1: R=0, G=255, B=255-f4.
REQ-023 seg2: R=f4, G=255, B=0; seg3: R=255, G=255-f4, B=0.
REQ-024 Latency SHALL be exactly 2 cycles from acceptance to m_axis_tvalid with m_axis_tready held high; throughput 1 beat/cycle.
REQ-025 When en=0, all pipeline registers SHALL hold; m_axis_* SHALL remain stable while tvalid&~tready.
REQ-026 Beats SHALL never be dropped, duplicated or reordered; tuser/tlast SHALL stay aligned with their pixel.
REQ-027 Counters update on stage-1 acceptance: accepted beat with tuser=1 SHALL load counter = its own flag (0 or 1); otherwise increment on flag.
REQ-028 Counters SHALL saturate at 0xFFFF (no wrap).
REQ-029 Bubbles (v1=0) SHALL not alter counters; tdata of invalid stages is don't-care.

Reset
REQ-030 ap_rst_n low SHALL immediately clear v1, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata (0x000000), sat_lo_cnt, sat_hi_cnt.
REQ-031 Reset mid-stream SHALL discard in-flight beats; first cycle after release s_axis_tready=1.
REQ-032 Reset release SHALL be synchronised by the integrator; block assumes deassertion is clock-aligned.

Verification
REQ-033 Flow: tdata=100<<34, m_tready=1 -> m_tdata=0x00FF6F exactly 2 cycles later, counters unchanged.
REQ-034 Clamp: tdata=-5 (signed) -> 0x0000FF, sat_lo_cnt+1; tdata=300<<34 -> 0xFF0300, sat_hi_cnt+1; tdata=255<<34 -> 0xFF0300, no flag.
REQ-035 Segment edges: idx 63,64,127,128,191,192 -> 0x00FCFF,0x00FFFF,0x00FF03,0x00FF00,0xFCFF00,0xFFFF00.
REQ-036 Backpressure: 20-beat burst, m_tready random 50% -> output sequence, tuser/tlast identical to input, held stable while stalled.
REQ-037 Frame reset: 3 hi-clamped beats, then tuser=1 beat with lo clamp -> sat_hi_cnt=0, sat_lo_cnt=1.
REQ-038 Reset: assert ap_rst_n=0 with 2 beats in flight -> m_tvalid=0 same cycle, counters 0, no stale beat after release.
